// File: rtl/cpu_hazard_unit.sv
// cpu_hazard_unit: decode-stage (p2) hazard, bypass and scoreboard unit.
//
// Tracks fixed-latency results in a short shift pipe so that p2 operands
// can be bypassed from the youngest matching stage. Variable-latency results
// are tracked in a per-register busy scoreboard that is cleared by the
// completion ports. A flush kills p2 and drops the younger in-flight
// variable-latency destinations.
//
// Handshake: p2_valid marks a decoded instruction. p2_issue is high in the
// cycle it is accepted. p2_stall is high when it must hold its fields
// unchanged into the next cycle. A flush discards the instruction, so both
// p2_issue and p2_stall are low in that cycle.
//
// Optional build macro CPU_HAZARD_CMP_FWD_EN: a completion in the current
// cycle masks the matching scoreboard bit in the hazard checks, so a
// dependent instruction issues in the completion cycle. Without it the
// registered scoreboard is used as-is, which adds a one-cycle bubble.
module cpu_hazard_unit #(
  parameter  int REG_BITS    = 5,
  parameter  int NUM_BYPASS  = 2,
  parameter  int MAX_LAT     = 2,
  parameter  int NUM_CMP     = 2,
  parameter  int NUM_RES     = 2,
  parameter  int FLUSH_DEPTH = 2,
  localparam int NUM_REGS    = 2 ** REG_BITS,
  localparam int LAT_BITS    = $clog2(MAX_LAT + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        p2_valid,
  input  logic                        p2_use_a,
  input  logic                        p2_use_b,
  input  logic [REG_BITS-1:0]         p2_src_a,
  input  logic [REG_BITS-1:0]         p2_src_b,
  input  logic [REG_BITS-1:0]         p2_dest,
  input  logic [LAT_BITS-1:0]         p2_lat,
  input  logic [REG_BITS-1:0]         p2_latent_dest,
  input  logic [NUM_RES-1:0]          p2_res_req,
  input  logic [NUM_RES-1:0]          res_busy,
  input  logic                        flush,
  input  logic [NUM_CMP-1:0]          cmp_valid,
  input  logic [NUM_CMP*REG_BITS-1:0] cmp_dest,
  output logic                        p2_issue,
  output logic                        p2_stall,
  output logic [NUM_BYPASS-1:0]       p2_byp_a,
  output logic [NUM_BYPASS-1:0]       p2_byp_b,
  output logic [NUM_REGS-1:0]         scoreboard,
  output logic [2:0]                  perf_count
);

  // Fixed-latency pipe; index k holds stage k+1 (index 0 is p3).
  logic                fx_valid [NUM_BYPASS];
  logic [REG_BITS-1:0] fx_dest  [NUM_BYPASS];
  logic [LAT_BITS-1:0] fx_lat   [NUM_BYPASS];

  // Variable-latency dests issued in the last FLUSH_DEPTH cycles.
  logic [REG_BITS-1:0] lt_dest [FLUSH_DEPTH];

  logic [NUM_REGS-1:0] sb_q, sb_n, cmp_mask, sb_eff;
  logic                flush_q;
  logic [2:0]          perf_q, perf_n;

  // Operand views so both sources share one checking loop.
  logic                  op_use [2];
  logic [REG_BITS-1:0]   op_src [2];
  logic [NUM_BYPASS-1:0] op_byp [2];
  logic [1:0]            raw_fix, raw_var;
  logic                  waw, data_haz, res_haz;

  assign op_use[0] = p2_use_a;
  assign op_use[1] = p2_use_b;
  assign op_src[0] = p2_src_a;
  assign op_src[1] = p2_src_b;

  // Registers completing this cycle, one bit per register.
  always_comb begin
    cmp_mask = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (cmp_valid[i]) cmp_mask[cmp_dest[i*REG_BITS +: REG_BITS]] = 1'b1;
    end
  end

`ifdef CPU_HAZARD_CMP_FWD_EN
  assign sb_eff = sb_q & ~cmp_mask;
`else
  assign sb_eff = sb_q;
`endif

  // Per-operand bypass select and RAW detection; only the youngest match counts.
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      logic found;
      found      = 1'b0;
      op_byp[o]  = '0;
      raw_fix[o] = 1'b0;
      raw_var[o] = 1'b0;
      if (op_use[o] && op_src[o] != '0) begin
        raw_var[o] = sb_eff[op_src[o]];
        for (int k = 0; k < NUM_BYPASS; k++) begin
          if (!found && fx_valid[k] && fx_dest[k] == op_src[o]) begin
            found = 1'b1;
            if (k + 1 >= int'(fx_lat[k])) op_byp[o][k] = 1'b1;
            else                          raw_fix[o]   = 1'b1;
          end
        end
      end
    end
  end

  assign p2_byp_a = op_byp[0];
  assign p2_byp_b = op_byp[1];

  assign waw      = (p2_latent_dest != '0) && sb_eff[p2_latent_dest];
  assign data_haz = (|raw_fix) || (|raw_var) || waw;
  assign res_haz  = |(p2_res_req & res_busy);
  assign p2_stall = p2_valid && !flush && (data_haz || res_haz);
  assign p2_issue = p2_valid && !flush && !(data_haz || res_haz);

  // Scoreboard next state: completions, then new latent dest, then flush clear.
  always_comb begin
    sb_n = sb_q & ~cmp_mask;
    if (p2_issue) sb_n[p2_latent_dest] = 1'b1;
    if (flush) begin
      for (int j = 0; j < FLUSH_DEPTH; j++) sb_n[lt_dest[j]] = 1'b0;
    end
    sb_n[0] = 1'b0;
  end

  // Perf classification for the current cycle; flush shadows one extra cycle.
  always_comb begin
    if (flush || flush_q)          perf_n = 3'd3;
    else if (p2_valid && data_haz) perf_n = 3'd1;
    else if (p2_valid && res_haz)  perf_n = 3'd2;
    else                           perf_n = 3'd0;
  end

  // All pipeline state: shift pipes, scoreboard and perf register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_BYPASS; k++) begin
        fx_valid[k] <= 1'b0;
        fx_dest[k]  <= '0;
        fx_lat[k]   <= '0;
      end
      for (int j = 0; j < FLUSH_DEPTH; j++) lt_dest[j] <= '0;
      sb_q    <= '0;
      flush_q <= 1'b0;
      perf_q  <= 3'd0;
    end else begin
      fx_valid[0] <= p2_issue && (p2_dest != '0);
      fx_dest[0]  <= p2_dest;
      fx_lat[0]   <= p2_lat;
      for (int k = 1; k < NUM_BYPASS; k++) begin
        fx_valid[k] <= fx_valid[k-1] && !flush;
        fx_dest[k]  <= fx_dest[k-1];
        fx_lat[k]   <= fx_lat[k-1];
      end
      lt_dest[0] <= p2_issue ? p2_latent_dest : '0;
      for (int j = 1; j < FLUSH_DEPTH; j++) begin
        lt_dest[j] <= flush ? '0 : lt_dest[j-1];
      end
      sb_q    <= sb_n;
      flush_q <= flush;
      perf_q  <= perf_n;
    end
  end

  assign scoreboard = sb_q;
  assign perf_count = perf_q;

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// tb_cpu_hazard_unit: directed scenarios plus random traffic for
// cpu_hazard_unit, checked against a list-based model of in-flight results.
module tb_cpu_hazard_unit;

  localparam int REG_BITS    = 5;
  localparam int NUM_REGS    = 2 ** REG_BITS;
  localparam int NUM_BYPASS  = 2;
  localparam int MAX_LAT     = 2;
  localparam int NUM_CMP     = 2;
  localparam int NUM_RES     = 2;
  localparam int FLUSH_DEPTH = 2;
  localparam int LAT_BITS    = $clog2(MAX_LAT + 1);

  logic                        clock, reset;
  logic                        p2_valid, p2_use_a, p2_use_b;
  logic [REG_BITS-1:0]         p2_src_a, p2_src_b, p2_dest, p2_latent_dest;
  logic [LAT_BITS-1:0]         p2_lat;
  logic [NUM_RES-1:0]          p2_res_req, res_busy;
  logic                        flush;
  logic [NUM_CMP-1:0]          cmp_valid;
  logic [NUM_CMP*REG_BITS-1:0] cmp_dest;
  logic                        p2_issue, p2_stall;
  logic [NUM_BYPASS-1:0]       p2_byp_a, p2_byp_b;
  logic [NUM_REGS-1:0]         scoreboard;
  logic [2:0]                  perf_count;

  cpu_hazard_unit #(
    .REG_BITS(REG_BITS), .NUM_BYPASS(NUM_BYPASS), .MAX_LAT(MAX_LAT),
    .NUM_CMP(NUM_CMP), .NUM_RES(NUM_RES), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .p2_valid(p2_valid),
    .p2_use_a(p2_use_a), .p2_use_b(p2_use_b),
    .p2_src_a(p2_src_a), .p2_src_b(p2_src_b), .p2_dest(p2_dest),
    .p2_lat(p2_lat), .p2_latent_dest(p2_latent_dest),
    .p2_res_req(p2_res_req), .res_busy(res_busy), .flush(flush),
    .cmp_valid(cmp_valid), .cmp_dest(cmp_dest),
    .p2_issue(p2_issue), .p2_stall(p2_stall),
    .p2_byp_a(p2_byp_a), .p2_byp_b(p2_byp_b),
    .scoreboard(scoreboard), .perf_count(perf_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard queue ----------------
  typedef struct packed {
    logic                  issue;
    logic                  stall;
    logic [NUM_BYPASS-1:0] byp_a;
    logic [NUM_BYPASS-1:0] byp_b;
    logic [NUM_REGS-1:0]   sb;
    logic [2:0]            perf;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // In-flight fixed results are a list of (dest, lat, age); age 1 = one
  // cycle after issue. Recent latent issues are a list of (dest, age).
  typedef struct { int dest; int lat; int age; } fx_t;
  typedef struct { int dest; int age; } lt_t;
  fx_t fix_list[$];
  lt_t lat_list[$];
  bit  busy_m [NUM_REGS];
  int  perf_m;
  bit  prev_flush;

  task automatic model_clear();
    foreach (busy_m[r]) busy_m[r] = 1'b0;
    fix_list.delete();
    lat_list.delete();
    perf_m     = 0;
    prev_flush = 1'b0;
  endtask

  function automatic bit completes_now(int r);
    for (int i = 0; i < NUM_CMP; i++)
      if (cmp_valid[i] && int'(cmp_dest[i*REG_BITS +: REG_BITS]) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy_eff(int r);
`ifdef CPU_HAZARD_CMP_FWD_EN
    return busy_m[r] && !completes_now(r);
`else
    return busy_m[r];
`endif
  endfunction

  task automatic check_src(input bit use_src, input int src,
                           output logic [NUM_BYPASS-1:0] byp, output bit raw);
    int best;
    byp  = '0;
    raw  = 1'b0;
    best = -1;
    if (use_src && src != 0) begin
      foreach (fix_list[j])
        if (fix_list[j].dest == src && (best < 0 || fix_list[j].age < fix_list[best].age))
          best = j;
      if (busy_eff(src)) raw = 1'b1;
      if (best >= 0) begin
        if (fix_list[best].age >= fix_list[best].lat) byp[fix_list[best].age-1] = 1'b1;
        else raw = 1'b1;
      end
    end
  endtask

  // Predict this cycle's outputs, push them, then advance the model one edge.
  task automatic model_step();
    exp_t e;
    logic [NUM_BYPASS-1:0] ba, bb;
    bit ra, rb, waw, data, res, stall, issue;
    fx_t nf[$];
    lt_t nl[$];
    check_src(p2_use_a, int'(p2_src_a), ba, ra);
    check_src(p2_use_b, int'(p2_src_b), bb, rb);
    waw   = (p2_latent_dest != 0) && busy_eff(int'(p2_latent_dest));
    data  = ra || rb || waw;
    res   = (p2_res_req & res_busy) != 0;
    stall = p2_valid && !flush && (data || res);
    issue = p2_valid && !flush && !stall;
    e.issue = issue;
    e.stall = stall;
    e.byp_a = ba;
    e.byp_b = bb;
    for (int r = 0; r < NUM_REGS; r++) e.sb[r] = busy_m[r];
    e.perf = 3'(perf_m);
    exp_q.push_back(e);

    if (reset) begin
      model_clear();
    end else begin
      if (flush || prev_flush)  perf_m = 3;
      else if (p2_valid && data) perf_m = 1;
      else if (p2_valid && res)  perf_m = 2;
      else                       perf_m = 0;
      prev_flush = flush;
      for (int i = 0; i < NUM_CMP; i++)
        if (cmp_valid[i]) busy_m[int'(cmp_dest[i*REG_BITS +: REG_BITS])] = 1'b0;
      if (issue) busy_m[int'(p2_latent_dest)] = 1'b1;
      if (flush) foreach (lat_list[j]) busy_m[lat_list[j].dest] = 1'b0;
      busy_m[0] = 1'b0;
      if (!flush) begin
        foreach (fix_list[j])
          if (fix_list[j].age < NUM_BYPASS)
            nf.push_back('{fix_list[j].dest, fix_list[j].lat, fix_list[j].age + 1});
        foreach (lat_list[j])
          if (lat_list[j].age < FLUSH_DEPTH)
            nl.push_back('{lat_list[j].dest, lat_list[j].age + 1});
        if (issue && p2_dest != 0) nf.push_back('{int'(p2_dest), int'(p2_lat), 1});
        if (issue && p2_latent_dest != 0) nl.push_back('{int'(p2_latent_dest), 1});
      end
      fix_list = nf;
      lat_list = nl;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit v, input bit ua, input int sa, input bit ub, input int sb,
                     input int d, input int l, input int ld, input int rq, input int rbz,
                     input bit fl, input int cv, input logic [NUM_CMP*REG_BITS-1:0] cd,
                     input bit rst);
    @(negedge clock);
    reset          = rst;
    p2_valid       = v;
    p2_use_a       = ua;
    p2_src_a       = REG_BITS'(sa);
    p2_use_b       = ub;
    p2_src_b       = REG_BITS'(sb);
    p2_dest        = REG_BITS'(d);
    p2_lat         = LAT_BITS'(l);
    p2_latent_dest = REG_BITS'(ld);
    p2_res_req     = NUM_RES'(rq);
    res_busy       = NUM_RES'(rbz);
    flush          = fl;
    cmp_valid      = NUM_CMP'(cv);
    cmp_dest       = cd;
    model_step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("p2_issue",   64'(p2_issue),   64'(e.issue));
      check("p2_stall",   64'(p2_stall),   64'(e.stall));
      check("p2_byp_a",   64'(p2_byp_a),   64'(e.byp_a));
      check("p2_byp_b",   64'(p2_byp_b),   64'(e.byp_b));
      check("scoreboard", 64'(scoreboard), 64'(e.sb));
      check("perf_count", 64'(perf_count), 64'(e.perf));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; p2_valid = 0; p2_use_a = 0; p2_use_b = 0;
    p2_src_a = '0; p2_src_b = '0; p2_dest = '0; p2_lat = LAT_BITS'(1);
    p2_latent_dest = '0; p2_res_req = '0; res_busy = '0; flush = 0;
    cmp_valid = '0; cmp_dest = '0;
    model_clear();
    repeat (2) @(posedge clock);

    // Reset state, then fixed bypass from stage 1 and stage 2.
    idle();
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, '0, 0);
    cyc(1, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    cyc(1, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    idle(); idle();
    // Two-cycle latency: one stall, then bypass from stage 2.
    cyc(1, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    idle(); idle();
    // Scoreboard RAW and WAW on reg 7, released by completion port 0.
    cyc(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, '0, 0);
    repeat (2) cyc(1, 1, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0, '0, 0);
    cyc(1, 1, 7, 0, 0, 0, 1, 7, 0, 0, 0, 1, {5'd0, 5'd7}, 0);
    repeat (2) cyc(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {5'd0, 5'd7}, 0);
    idle();
    // Flush right after a latent issue and a fixed issue.
    cyc(1, 0, 0, 0, 0, 2, 2, 9, 0, 0, 0, 0, '0, 0);
    cyc(1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0, '0, 0);
    repeat (3) cyc(1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    // Resource hazard, double completion with simultaneous issue, latent 0.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 3, {5'd5, 5'd5}, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    idle();
    // Reset while a reader of reg 7 is stalled.
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, {5'd5, 5'd6}, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, '0, 0);
    cyc(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    cyc(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 1);
    cyc(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0);
    idle();

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_CMP*REG_BITS-1:0] cd;
      int cv;
      cv = 0;
      for (int i = 0; i < NUM_CMP; i++) begin
        cd[i*REG_BITS +: REG_BITS] = REG_BITS'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) cv = cv | (1 << i);
      end
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 7),
          $urandom_range(0, 3) != 0, $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(1, MAX_LAT),
          ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : 0,
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0,
          $urandom_range(0, 3),
          $urandom_range(0, 15) == 0, cv, cd,
          $urandom_range(0, 299) == 0);
    end

    idle();
    @(negedge clock);
    #5;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_unit.md
Name: cpu_hazard_unit

Overview:
- Parametrised issue-stage hazard, bypass and scoreboard unit for the decode (p2) stage.
- Generalises hazard handling in four directions: any register count, any bypass depth, per-instruction fixed latency, and multiple completion ports with resource masks.
- Adds a WAW check for variable-latency results and a depth-configurable flush clear.
- The decoder supplies decoded operand/dest fields; this block returns the stall decision, bypass selects and per-cycle perf classification.

Parameters:
- REG_BITS, 5, register index width; NUM_REGS = 2**REG_BITS; register 0 is never busy.
- NUM_BYPASS, 2, fixed-latency pipeline stages tracked for bypass (stage 1 = p3). Must be >= MAX_LAT.
- MAX_LAT, 2, largest fixed latency accepted on p2_lat.
- NUM_CMP, 2, variable-latency completion ports (e.g. memory, divider/FPU).
- NUM_RES, 2, shared resources checked via masks.
- FLUSH_DEPTH, 2, in-flight stages whose latent dests are cleared on flush.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- p2_valid  in  1  decoded instruction present
- p2_use_a / p2_use_b  in  1 each  operand read enables
- p2_src_a / p2_src_b  in  REG_BITS each  source registers
- p2_dest  in  REG_BITS  fixed-latency dest (0 = none)
- p2_lat  in  clog2(MAX_LAT+1)  fixed latency, 1..MAX_LAT
- p2_latent_dest  in  REG_BITS  variable-latency dest (0 = none)
- p2_res_req  in  NUM_RES  resources needed
- res_busy  in  NUM_RES  resource busy flags
- flush  in  1  jump taken downstream
- cmp_valid  in  NUM_CMP  completion strobes
- cmp_dest  in  NUM_CMP*REG_BITS  completing registers, port i at [i*REG_BITS +: REG_BITS]
- p2_issue  out  1  instruction accepted this cycle
- p2_stall  out  1  p2 must hold
- p2_byp_a / p2_byp_b  out  NUM_BYPASS each  one-hot bypass stage select, 0 = register file
- scoreboard  out  NUM_REGS  registered busy bits
- perf_count  out  3  0 OK, 1 data hazard, 2 resource hazard, 3 flush

Behaviour:
- Fixed-latency pipe: NUM_BYPASS registered entries of {valid, dest, lat}.
  - Stage 1 loads {p2_issue && p2_dest!=0, p2_dest, p2_lat}; stage k loads stage k-1.
  - Entry at stage k is "ready" when k >= lat.
- Bypass: for each used, nonzero source, select the lowest k whose valid entry dest matches and is ready. Only the youngest match is considered.
- Data hazards (each gated by use_x and src_x != 0):
  - RAW-fixed: youngest matching entry is not ready.
  - RAW-var: scoreboard[src] set.
  - WAW: p2_latent_dest != 0 and scoreboard[p2_latent_dest] set.
- Resource hazard: |(p2_res_req & res_busy).
- Stall and issue:
  - p2_stall = p2_valid && !flush && any hazard.
  - p2_issue = p2_valid && !flush && !p2_stall.
  - Flush kills p2 with p2_stall = 0.
- Scoreboard next-state, applied in this order:
  - Clear cmp_dest[i] for each cmp_valid[i].
  - Set p2_latent_dest if p2_issue.
  - On flush, clear the latent dests held in latent-tracking stages 1..FLUSH_DEPTH.
  - Force bit 0 to 0.
- Latent-tracking pipe: FLUSH_DEPTH registers, loaded with p2_issue ? p2_latent_dest : 0.
- Flush also invalidates every fixed-latency entry and every latent-tracking entry.
- Completion to a non-busy register is a no-op. Duplicate completions in one cycle are allowed.
- Without the optional feature, hazards use the registered scoreboard only, so completion removes a hazard one cycle later.
- perf_count is registered, one cycle late:
  - 3 if flush now or in the previous cycle;
  - else 1 for a data hazard;
  - else 2 for a resource hazard;
  - else 0.
- Reset: scoreboard = 0, all pipe entries invalid/0, perf_count = 0. Outputs are combinational from cleared state: p2_byp_* = 0; p2_issue and p2_stall follow their equations. Reset mid-operation drops all in-flight state.

Optional Feature:
- Macro: CPU_HAZARD_CMP_FWD_EN.
- Defined: a cmp_valid/cmp_dest this cycle masks the matching scoreboard bit in the RAW-var and WAW checks, so a dependent instruction issues in the completion cycle.
- Undefined: hazards use the registered scoreboard only; a one-cycle bubble follows each completion.

Test Plan:
- Fixed bypass: issue dest=3 lat=1, then src_a=3 next cycle -> p2_issue=1, p2_byp_a=01. The following cycle with src_a=3 -> p2_byp_a=10.
- Multi-cycle latency: issue dest=4 lat=2, then src_b=4 immediately -> p2_stall=1 for 1 cycle, then issue with p2_byp_b=10. perf_count=1 one cycle after the stall.
- Scoreboard and WAW: latent_dest=7 issued; reader src_a=7 and writer latent_dest=7 stall until cmp_valid[0], cmp_dest=7.
  - Macro undefined: issue 1 cycle after completion.
  - Macro defined: issue in the completion cycle.
- Flush: latent_dest=9 issued, flush next cycle -> scoreboard[9]=0 after the edge, fixed pipe empty, p2_issue=0, perf_count=3 for 2 cycles.
- Resource and simultaneous events: res_req=01 with res_busy=01 -> stall, perf_count=2. Two cmp ports both completing reg 5 while p2 issues latent_dest=6 -> bits 5=0, 6=1. latent_dest=0 never sets bit 0.
- Reset mid-stall: scoreboard=0x80, reset asserted -> scoreboard=0 after the edge; the stalled reader of reg 7 issues the next cycle.
